// File: rtl/key_input_array.sv
// key_input_array: synchronise, debounce and edge-detect CHANNELS key pins and queue key events
// in a valid/ready FIFO. Define KEY_INPUT_ARRAY_REPEAT_EN to build the per-channel auto-repeat.
module key_input_array #(
  parameter int CHANNELS            = 8,
  parameter int CLOCK_HZ            = 12_000_000,
  parameter int SAMPLE_HZ           = 10_000,
  parameter int FILTER_COUNT        = 3,
  parameter int ACTIVE_LOW          = 1,
  parameter int FIFO_DEPTH          = 4,
  parameter int REPEAT_DELAY_TICKS  = 5000,
  parameter int REPEAT_PERIOD_TICKS = 1000
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                enable,
  input  logic [CHANNELS-1:0] async_in,
  output logic [CHANNELS-1:0] key_state,
  output logic [CHANNELS-1:0] press_pulse,
  output logic [CHANNELS-1:0] release_pulse,
  output logic                event_valid,
  input  logic                event_ready,
  output logic [((CHANNELS > 1) ? $clog2(CHANNELS) : 1)-1:0] event_channel,
  output logic                event_pressed,
  output logic                event_repeat,
  output logic                overflow,
  input  logic                overflow_clear
);
  localparam int CW  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
  localparam int DIV = CLOCK_HZ / SAMPLE_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int FW  = $clog2(FILTER_COUNT + 1);
  localparam int AW  = $clog2(FIFO_DEPTH);
  localparam int EW  = CW + 2;

  logic [CHANNELS-1:0] pin_level, sync_meta, sync_q;
  assign pin_level = (ACTIVE_LOW != 0) ? ~async_in : async_in;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_meta <= '0;
      sync_q    <= '0;
    end else begin
      sync_meta <= pin_level;
      sync_q    <= sync_meta;
    end
  end

  logic [PW-1:0] presc;
  logic          tick;
  assign tick = enable && (presc == PW'(DIV - 1));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n)              presc <= '0;
    else if (!enable || tick)  presc <= '0;
    else                       presc <= presc + 1'b1;
  end

  logic [FW-1:0] filt_cnt [CHANNELS];

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      key_state     <= '0;
      press_pulse   <= '0;
      release_pulse <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) filt_cnt[i] <= '0;
    end else begin
      press_pulse   <= '0;
      release_pulse <= '0;
      if (tick) begin
        for (int unsigned i = 0; i < CHANNELS; i++) begin
          if (sync_q[i] != key_state[i]) begin
            if (filt_cnt[i] == FW'(FILTER_COUNT - 1)) begin
              key_state[i]     <= sync_q[i];
              filt_cnt[i]      <= '0;
              press_pulse[i]   <= sync_q[i];
              release_pulse[i] <= ~sync_q[i];
            end else begin
              filt_cnt[i] <= filt_cnt[i] + 1'b1;
            end
          end else begin
            filt_cnt[i] <= '0;
          end
        end
      end
    end
  end

  logic [CHANNELS-1:0] repeat_pulse;
`ifdef KEY_INPUT_ARRAY_REPEAT_EN
  localparam int RMAX = (REPEAT_DELAY_TICKS > REPEAT_PERIOD_TICKS) ? REPEAT_DELAY_TICKS
                                                                   : REPEAT_PERIOD_TICKS;
  localparam int RW   = $clog2(RMAX + 1);
  logic [RW-1:0]       hold_cnt [CHANNELS];
  logic [CHANNELS-1:0] hold_periodic;

  // Hold ticks count only while the sample agrees the key is still down.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      repeat_pulse  <= '0;
      hold_periodic <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) hold_cnt[i] <= '0;
    end else begin
      repeat_pulse <= '0;
      for (int unsigned i = 0; i < CHANNELS; i++) begin
        if (press_pulse[i] || release_pulse[i]) begin
          hold_cnt[i]      <= '0;
          hold_periodic[i] <= 1'b0;
        end else if (tick && key_state[i] && sync_q[i]) begin
          if (hold_cnt[i] + 1'b1 == (hold_periodic[i] ? RW'(REPEAT_PERIOD_TICKS)
                                                      : RW'(REPEAT_DELAY_TICKS))) begin
            hold_cnt[i]      <= '0;
            hold_periodic[i] <= 1'b1;
            repeat_pulse[i]  <= 1'b1;
          end else begin
            hold_cnt[i] <= hold_cnt[i] + 1'b1;
          end
        end
      end
    end
  end
`else
  assign repeat_pulse = '0;
`endif

  logic [CHANNELS-1:0] pend, pend_pressed, pend_repeat;
  logic [CHANNELS-1:0] new_event, grant, taken, replace;
  logic [CW-1:0]       grant_idx;
  logic [AW:0]         fifo_count;
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [EW-1:0]       fifo_mem [FIFO_DEPTH];
  logic [EW-1:0]       head;
  logic                fifo_full, push, pop;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int unsigned i = 0; i < CHANNELS; i++) begin
      if (pend[i] && (grant == '0)) begin
        grant[i]  = 1'b1;
        grant_idx = CW'(i);
      end
    end
  end

  assign fifo_full = (fifo_count == (AW + 1)'(FIFO_DEPTH));
  assign push      = !fifo_full && (pend != '0);
  assign pop       = event_valid && event_ready;
  assign new_event = press_pulse | release_pulse | repeat_pulse;
  assign taken     = grant & {CHANNELS{push}};
  // An event landing on a flag being enqueued this very cycle loses nothing.
  assign replace   = new_event & pend & ~taken;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      pend         <= '0;
      pend_pressed <= '0;
      pend_repeat  <= '0;
      overflow     <= 1'b0;
    end else begin
      pend         <= (pend & ~taken) | new_event;
      pend_pressed <= (pend_pressed & ~new_event) | press_pulse | repeat_pulse;
      pend_repeat  <= (pend_repeat & ~new_event) | repeat_pulse;
      if (replace != '0)       overflow <= 1'b1;
      else if (overflow_clear) overflow <= 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (push) fifo_mem[wr_ptr] <= {grant_idx, pend_pressed[grant_idx], pend_repeat[grant_idx]};
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: ;
      endcase
    end
  end

  assign head          = fifo_mem[rd_ptr];
  assign event_valid   = (fifo_count != '0);
  assign event_channel = event_valid ? head[EW-1:2] : '0;
  assign event_pressed = event_valid & head[1];
  assign event_repeat  = event_valid & head[0];
endmodule

// File: tb/tb_key_input_array.sv
// Bench for key_input_array: table vectors, directed corner sequences and a random phase
// scored against a tick-level behavioural model of the key/event rules.
module tb_key_input_array;
  localparam int CH     = 8;
  localparam int CLK_HZ = 160_000;
  localparam int SMP_HZ = 10_000;
  localparam int DIV    = CLK_HZ / SMP_HZ;
  localparam int FC     = 3;
  localparam int DEPTH  = 4;
  localparam int RD     = 5;
  localparam int RP     = 2;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          enable = 1'b1;
  logic          event_ready = 1'b1;
  logic          overflow_clear = 1'b0;
  logic [CH-1:0] async_in = '1;
  logic [CH-1:0] key_state, press_pulse, release_pulse;
  logic          event_valid, event_pressed, event_repeat, overflow;
  logic [2:0]    event_channel;

  key_input_array #(
    .CHANNELS(CH), .CLOCK_HZ(CLK_HZ), .SAMPLE_HZ(SMP_HZ), .FILTER_COUNT(FC),
    .ACTIVE_LOW(1), .FIFO_DEPTH(DEPTH), .REPEAT_DELAY_TICKS(RD), .REPEAT_PERIOD_TICKS(RP)
  ) dut (
    .clock(clock), .reset_n(reset_n), .enable(enable), .async_in(async_in),
    .key_state(key_state), .press_pulse(press_pulse), .release_pulse(release_pulse),
    .event_valid(event_valid), .event_ready(event_ready), .event_channel(event_channel),
    .event_pressed(event_pressed), .event_repeat(event_repeat), .overflow(overflow),
    .overflow_clear(overflow_clear)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: pin level seen two clocks late, ticks every DIV enabled clocks,
  // FC consecutive disagreeing samples flip the level; events queue in tick then channel order.
  typedef struct packed { logic [2:0] ch; logic pressed; logic rpt; } ev_t;
  ev_t           exp_q[$];
  logic [CH-1:0] m_state, m_press, m_rel, h1, h2, smp;
  int            run;
  int            diff[CH];
  int            hold[CH];
  bit            chk_en = 1'b0;
  int            n_p4 = 0, n_r4 = 0, n_rel4 = 0;

  always @(posedge clock) begin
    if (!reset_n) begin
      m_state = '0; m_press = '0; m_rel = '0; h1 = '0; h2 = '0; run = 0;
      for (int i = 0; i < CH; i++) begin diff[i] = 0; hold[i] = 0; end
      exp_q.delete();
    end else begin
      smp = h2; h2 = h1; h1 = ~async_in;
      m_press = '0; m_rel = '0;
      if (!enable) run = 0;
      else begin
        run++;
        if (run % DIV == 0) begin
          for (int i = 0; i < CH; i++) begin
            if (smp[i] != m_state[i]) begin
              diff[i]++;
              if (diff[i] == FC) begin
                m_state[i] = smp[i];
                diff[i] = 0;
                hold[i] = 0;
                if (smp[i]) m_press[i] = 1'b1; else m_rel[i] = 1'b1;
                exp_q.push_back(ev_t'{3'(i), smp[i], 1'b0});
              end
            end else begin
              diff[i] = 0;
`ifdef KEY_INPUT_ARRAY_REPEAT_EN
              if (m_state[i]) begin
                hold[i]++;
                if (hold[i] == RD || (hold[i] > RD && (hold[i] - RD) % RP == 0))
                  exp_q.push_back(ev_t'{3'(i), 1'b1, 1'b1});
              end
`endif
            end
          end
        end
      end
    end
  end

  always @(negedge clock) begin
    if (reset_n && chk_en) begin
      check("key_state", key_state, m_state);
      check("press_pulse", press_pulse, m_press);
      check("release_pulse", release_pulse, m_rel);
      if (event_valid && event_ready) begin
        if (exp_q.size() == 0) check("unexpected_event_valid", event_valid, 1'b0);
        else begin
          ev_t e;
          e = exp_q.pop_front();
          check("ev_channel", event_channel, e.ch);
          check("ev_pressed", event_pressed, e.pressed);
          check("ev_repeat", event_repeat, e.rpt);
        end
      end
    end
    if (reset_n && event_valid && event_ready && event_channel == 3'd4) begin
      if (event_repeat) n_r4++;
      else if (event_pressed) n_p4++;
      else n_rel4++;
    end
  end

  task automatic drive_pins(input logic [CH-1:0] pressed);
    @(posedge clock); #1;
    async_in = ~pressed;
  endtask

  task automatic ticks(input int n);
    repeat (n * DIV) @(posedge clock);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct { logic [CH-1:0] pressed; int n_ticks; logic [CH-1:0] exp_key; string name; } vec_t;
  vec_t vecs[8];

  initial begin
    int          found, lat, pulse_seen, valid_seen;
    logic [CH-1:0] pr;
    logic        ovf_exp[5];

    vecs[0] = '{8'h00, 5, 8'h00, "idle"};
    vecs[1] = '{8'h08, 4, 8'h08, "press_ch3"};
    vecs[2] = '{8'h00, 4, 8'h00, "release_ch3"};
    vecs[3] = '{8'h01, 2, 8'h00, "short_ch0_rejected"};
    vecs[4] = '{8'h00, 4, 8'h00, "after_short"};
    vecs[5] = '{8'h81, 4, 8'h81, "press_ch0_ch7"};
    vecs[6] = '{8'h80, 4, 8'h80, "release_ch0"};
    vecs[7] = '{8'h00, 4, 8'h00, "release_all"};
    ovf_exp = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};

    // Reset values with all pins at the released level
    repeat (5) @(negedge clock);
    check("rst_key_state", key_state, 0);
    check("rst_press", press_pulse, 0);
    check("rst_release", release_pulse, 0);
    check("rst_valid", event_valid, 0);
    check("rst_channel", event_channel, 0);
    check("rst_pressed", event_pressed, 0);
    check("rst_repeat", event_repeat, 0);
    check("rst_overflow", overflow, 0);
    @(posedge clock); #1 reset_n = 1'b1;
    chk_en = 1'b1;
    pulse_seen = 0; valid_seen = 0;
    repeat (10 * DIV) begin
      @(negedge clock);
      if (press_pulse != '0 || release_pulse != '0) pulse_seen = 1;
      if (event_valid) valid_seen = 1;
    end
    check("post_rst_pulses", pulse_seen, 0);
    check("post_rst_valid", valid_seen, 0);

    for (int v = 0; v < 8; v++) begin
      drive_pins(vecs[v].pressed);
      ticks(vecs[v].n_ticks);
      @(negedge clock);
      check(vecs[v].name, key_state, vecs[v].exp_key);
    end

    // Bounce: ch0 low for 2 ticks then high, repeatedly
    valid_seen = 0;
    for (int b = 0; b < 5; b++) begin
      drive_pins(8'h01);
      repeat (2 * DIV) begin @(negedge clock); if (event_valid) valid_seen = 1; end
      drive_pins(8'h00);
      repeat (2 * DIV) begin @(negedge clock); if (event_valid) valid_seen = 1; end
      check("bounce_key0", key_state[0], 1'b0);
    end
    check("bounce_no_event", valid_seen, 0);

    // Clean press on ch3: latency bound, 1-cycle pulse, event 2 cycles later
    drive_pins(8'h08);
    found = 0; lat = 0;
    for (int c = 1; c <= 80 && found == 0; c++) begin
      @(negedge clock);
      if (key_state[3]) begin found = 1; lat = c; end
    end
    check("clean_press_seen", found, 1);
    check("clean_press_latency_ok", (lat >= 1 && lat - 1 <= 2 + FC * DIV + 1), 1);
    check("clean_press_pulse_hi", press_pulse[3], 1'b1);
    @(negedge clock);
    check("clean_press_pulse_lo", press_pulse[3], 1'b0);
    check("clean_ev_not_yet", event_valid, 1'b0);
    @(negedge clock);
    check("clean_ev_valid", event_valid, 1'b1);
    check("clean_ev_channel", event_channel, 3);
    check("clean_ev_pressed", event_pressed, 1'b1);
    check("clean_ev_repeat", event_repeat, 1'b0);
    drive_pins(8'h00);
    ticks(4);

    // Simultaneous press of ch1, ch5, ch6
    drive_pins(8'h62);
    found = 0;
    for (int c = 0; c < 100 && found == 0; c++) begin
      @(negedge clock);
      if (event_valid) found = 1;
    end
    check("sim_seen", found, 1);
    check("sim_first_ch", event_channel, 1);
    @(negedge clock);
    check("sim_second_valid", event_valid, 1'b1);
    check("sim_second_ch", event_channel, 5);
    @(negedge clock);
    check("sim_third_valid", event_valid, 1'b1);
    check("sim_third_ch", event_channel, 6);
    @(negedge clock);
    check("sim_drained", event_valid, 1'b0);
    drive_pins(8'h00);
    ticks(4);

`ifdef KEY_INPUT_ARRAY_REPEAT_EN
    // Auto-repeat on ch4 held 12 ticks after acceptance
    n_p4 = 0; n_r4 = 0; n_rel4 = 0;
    drive_pins(8'h10);
    found = 0;
    for (int c = 0; c < 80 && found == 0; c++) begin
      @(negedge clock);
      if (key_state[4]) found = 1;
    end
    check("rpt_press_seen", found, 1);
    repeat (12 * DIV) @(posedge clock);
    #1 async_in = '1;
    ticks(5);
    check("rpt_press_events", n_p4, 1);
    check("rpt_repeat_events", n_r4, 4);
    check("rpt_release_events", n_rel4, 1);
`endif

    // Overflow: six ch2 events with the consumer stalled
    chk_en = 1'b0;
    @(posedge clock); #1 event_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      drive_pins((k % 2 == 0) ? 8'h04 : 8'h00);
      ticks(4);
      if (k == 4) begin
        @(negedge clock);
        check("ovf_after5_clear", overflow, 1'b0);
        check("ovf_after5_valid", event_valid, 1'b1);
      end
    end
    @(negedge clock);
    check("ovf_set", overflow, 1'b1);
    @(posedge clock); #1 event_ready = 1'b1;
    for (int j = 0; j < 5; j++) begin
      @(negedge clock);
      check("ovf_pop_valid", event_valid, 1'b1);
      check("ovf_pop_ch", event_channel, 2);
      check("ovf_pop_pressed", event_pressed, ovf_exp[j]);
    end
    @(negedge clock);
    check("ovf_fifo_empty", event_valid, 1'b0);
    check("ovf_sticky", overflow, 1'b1);
    @(posedge clock); #1 overflow_clear = 1'b1;
    @(posedge clock); #1 overflow_clear = 1'b0;
    @(negedge clock);
    check("ovf_cleared", overflow, 1'b0);

    // Reset mid-run, then randomized phase against the model
    @(posedge clock); #1 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    event_ready = 1'b1;
    @(negedge clock);
    check("rerst_valid", event_valid, 1'b0);
    check("rerst_overflow", overflow, 1'b0);
    chk_en = 1'b1;
    pr = '0;
    for (int it = 0; it < 80; it++) begin
      int unsigned r;
      r = $urandom % 8;
      if (r == 0) begin
        @(posedge clock); #1 enable = 1'b0;
        repeat ($urandom_range(3, 40)) @(posedge clock);
        #1 enable = 1'b1;
      end else begin
        pr[$urandom % CH] ^= 1'b1;
        if (r == 1) pr[$urandom % CH] ^= 1'b1;
        drive_pins(pr);
        repeat ($urandom_range(1, 90)) @(posedge clock);
      end
    end
    drive_pins(8'h00);
    ticks(8);
    @(negedge clock);
    check("rand_events_drained", exp_q.size(), 0);
    check("rand_no_overflow", overflow, 1'b0);
    check("rand_final_keys", key_state, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
